// File: rtl/empty_ptr_storage.sv
// Free-list of data-table pointers: show-ahead FIFO, RAM plus one-entry head register.
// Latency: a push into an empty list is the head one cycle later; pops sustain one per cycle.
// Backpressure: a push is dropped while the list is full unless a pop happens in the same cycle. A dropped push sets sticky overflow.
module empty_ptr_storage #(
  // Matches TABLE_ADDR_WIDTH of the hash table; capacity is 2**A_WIDTH pointers.
  parameter int A_WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               srst_i,
  input  logic [A_WIDTH-1:0] add_empty_ptr_i,
  input  logic               add_empty_ptr_en_i,
  output logic [A_WIDTH-1:0] next_empty_ptr_o,
  output logic               next_empty_ptr_val_o,
  input  logic               next_empty_ptr_rd_ack_i,
  output logic [A_WIDTH:0]   used_words_o,
  output logic               full_o,
  output logic               overflow_o
);

  localparam int DEPTH = 1 << A_WIDTH;

  // The head register holds the oldest pointer; the RAM holds the remaining pointers in order.
  logic [A_WIDTH-1:0] mem [DEPTH];
  logic [A_WIDTH-1:0] wr_ptr_q;
  logic [A_WIDTH-1:0] rd_ptr_q;
  logic [A_WIDTH-1:0] head_q;
  logic [A_WIDTH:0]   used_q;
  logic               ovf_q;

  logic head_vld;
  logic full;
  logic ram_empty;
  logic pop;
  logic push;
  logic drop;
  logic ram_wr_en;
  logic head_from_ram;
  logic head_from_in;

  // The head is valid whenever anything is stored.
  // Full is the top bit of the occupancy count, because the count never exceeds DEPTH.
  assign head_vld  = (used_q != '0);
  assign full      = used_q[A_WIDTH];
  // The RAM holds used_q - 1 entries when the head is valid. It is therefore empty at occupancy 0 or 1.
  assign ram_empty = (used_q <= (A_WIDTH+1)'(1));

  assign pop  = next_empty_ptr_rd_ack_i & head_vld;
  assign push = add_empty_ptr_en_i & (~full | pop);
  assign drop = add_empty_ptr_en_i & full & ~pop;

  // Steer each accepted pointer to the head register (bypass) or into the RAM.
  // Also decide whether a pop refills the head from the RAM.
  always_comb begin
    ram_wr_en     = 1'b0;
    head_from_ram = 1'b0;
    head_from_in  = 1'b0;
    if (!srst_i) begin
      if (push) begin
        // An empty list, or a one-entry list being popped, forwards the new pointer straight to the head.
        if (!head_vld || (pop && ram_empty)) begin
          head_from_in = 1'b1;
        end else begin
          ram_wr_en = 1'b1;
        end
      end
      if (pop && !ram_empty) begin
        head_from_ram = 1'b1;
      end
    end
  end

  // RAM write port: the storage itself has no reset, and only the pointers give it meaning.
  always_ff @(posedge clk_i) begin
    if (ram_wr_en) begin
      mem[wr_ptr_q] <= add_empty_ptr_i;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  // The pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      ovf_q    <= 1'b0;
    end else if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (ram_wr_en) begin
        wr_ptr_q <= wr_ptr_q + A_WIDTH'(1);
      end
      if (head_from_ram) begin
        rd_ptr_q <= rd_ptr_q + A_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   used_q <= used_q + (A_WIDTH+1)'(1);
        2'b01:   used_q <= used_q - (A_WIDTH+1)'(1);
        default: used_q <= used_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Show-ahead head register.
  // It loads either the bypassed push data or the next RAM entry, and holds its value while the list is empty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q <= '0;
    end else if (head_from_in) begin
      head_q <= add_empty_ptr_i;
    end else if (head_from_ram) begin
      head_q <= mem[rd_ptr_q];
    end
  end

  assign next_empty_ptr_o     = head_q;
  assign next_empty_ptr_val_o = head_vld;
  assign used_words_o         = used_q;
  assign full_o               = full;
  assign overflow_o           = ovf_q;

endmodule

// File: tb/tb_empty_ptr_storage.sv
// Directed bench for empty_ptr_storage with A_WIDTH=4.
// Inputs are driven and outputs sampled 1ns after each rising edge.
// Expected values are hand-derived constants and loop indices.
module tb_empty_ptr_storage;

  localparam int AW = 4;

  logic          clk_i;
  logic          rst_n_i;
  logic          srst_i;
  logic [AW-1:0] add_empty_ptr_i;
  logic          add_empty_ptr_en_i;
  logic [AW-1:0] next_empty_ptr_o;
  logic          next_empty_ptr_val_o;
  logic          next_empty_ptr_rd_ack_i;
  logic [AW:0]   used_words_o;
  logic          full_o;
  logic          overflow_o;

  int total;
  int bad;

  empty_ptr_storage #(.A_WIDTH(AW)) dut (
    .clk_i                   (clk_i),
    .rst_n_i                 (rst_n_i),
    .srst_i                  (srst_i),
    .add_empty_ptr_i         (add_empty_ptr_i),
    .add_empty_ptr_en_i      (add_empty_ptr_en_i),
    .next_empty_ptr_o        (next_empty_ptr_o),
    .next_empty_ptr_val_o    (next_empty_ptr_val_o),
    .next_empty_ptr_rd_ack_i (next_empty_ptr_rd_ack_i),
    .used_words_o            (used_words_o),
    .full_o                  (full_o),
    .overflow_o              (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge pass, then return inputs to idle.
  task automatic drive_cycle(input logic en, input logic [AW-1:0] d, input logic ack, input logic s);
    add_empty_ptr_en_i      = en;
    add_empty_ptr_i         = d;
    next_empty_ptr_rd_ack_i = ack;
    srst_i                  = s;
    @(posedge clk_i);
    #1;
    add_empty_ptr_en_i      = 1'b0;
    add_empty_ptr_i         = '0;
    next_empty_ptr_rd_ack_i = 1'b0;
    srst_i                  = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [AW-1:0] exp);
    check_val({tag, "_val"}, 32'(next_empty_ptr_val_o), 32'd1);
    check_val({tag, "_ptr"}, 32'(next_empty_ptr_o), 32'(exp));
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic fill_0_to_15();
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, AW'(i), 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n_i                 = 1'b0;
    srst_i                  = 1'b0;
    add_empty_ptr_i         = '0;
    add_empty_ptr_en_i      = 1'b0;
    next_empty_ptr_rd_ack_i = 1'b0;

    // Reset state
    #3;
    check_val("rst_val",  32'(next_empty_ptr_val_o), 32'd0);
    check_val("rst_used", 32'(used_words_o), 32'd0);
    check_val("rst_full", 32'(full_o), 32'd0);
    check_val("rst_ovf",  32'(overflow_o), 32'd0);
    check_val("rst_ptr",  32'(next_empty_ptr_o), 32'd0);
    #9 rst_n_i = 1'b1;

    // 1. Init fill and drain
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    drive_cycle(1'b1, 4'h0, 1'b0, 1'b0);
    check_val("t1_first_val", 32'(next_empty_ptr_val_o), 32'd1);
    check_val("t1_first_ptr", 32'(next_empty_ptr_o), 32'd0);
    check_val("t1_first_full", 32'(full_o), 32'd0);
    for (int i = 1; i < 16; i++) drive_cycle(1'b1, AW'(i), 1'b0, 1'b0);
    check_val("t1_full", 32'(full_o), 32'd1);
    check_val("t1_used16", 32'(used_words_o), 32'd16);
    for (int i = 0; i < 16; i++) pop_expect("t1_drain", AW'(i));
    check_val("t1_end_val", 32'(next_empty_ptr_val_o), 32'd0);
    check_val("t1_end_used", 32'(used_words_o), 32'd0);

    // 2. Empty-list push latency and ignored ack
    drive_cycle(1'b1, 4'h7, 1'b0, 1'b0);
    check_val("t2_val", 32'(next_empty_ptr_val_o), 32'd1);
    check_val("t2_ptr", 32'(next_empty_ptr_o), 32'h7);
    check_val("t2_used", 32'(used_words_o), 32'd1);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("t2_pop_val", 32'(next_empty_ptr_val_o), 32'd0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("t2_underflow_used", 32'(used_words_o), 32'd0);
    check_val("t2_underflow_val", 32'(next_empty_ptr_val_o), 32'd0);

    // 3a. Simultaneous push and pop with one entry
    drive_cycle(1'b1, 4'h3, 1'b0, 1'b0);
    check_val("t3a_head3", 32'(next_empty_ptr_o), 32'h3);
    drive_cycle(1'b1, 4'h9, 1'b1, 1'b0);
    check_val("t3a_head9", 32'(next_empty_ptr_o), 32'h9);
    check_val("t3a_val", 32'(next_empty_ptr_val_o), 32'd1);
    check_val("t3a_used", 32'(used_words_o), 32'd1);
    pop_expect("t3a_drain", 4'h9);
    check_val("t3a_end_used", 32'(used_words_o), 32'd0);

    // 3b. Simultaneous push and pop while full
    fill_0_to_15();
    check_val("t3b_full", 32'(full_o), 32'd1);
    drive_cycle(1'b1, 4'hA, 1'b1, 1'b0);
    check_val("t3b_used", 32'(used_words_o), 32'd16);
    check_val("t3b_ovf", 32'(overflow_o), 32'd0);
    for (int i = 1; i < 16; i++) pop_expect("t3b_drain", AW'(i));
    pop_expect("t3b_last", 4'hA);
    check_val("t3b_end_used", 32'(used_words_o), 32'd0);

    // 4. Overflow
    fill_0_to_15();
    drive_cycle(1'b1, 4'h5, 1'b0, 1'b0);
    check_val("t4_ovf", 32'(overflow_o), 32'd1);
    check_val("t4_used", 32'(used_words_o), 32'd16);
    for (int i = 0; i < 16; i++) pop_expect("t4_drain", AW'(i));
    check_val("t4_end_val", 32'(next_empty_ptr_val_o), 32'd0);
    check_val("t4_ovf_sticky", 32'(overflow_o), 32'd1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    check_val("t4_ovf_clr", 32'(overflow_o), 32'd0);

    // 5a. Synchronous clear dominates push and pop
    for (int i = 0; i < 9; i++) drive_cycle(1'b1, AW'(i), 1'b0, 1'b0);
    check_val("t5_used9", 32'(used_words_o), 32'd9);
    drive_cycle(1'b1, 4'h1, 1'b1, 1'b1);
    check_val("t5_srst_used", 32'(used_words_o), 32'd0);
    check_val("t5_srst_val", 32'(next_empty_ptr_val_o), 32'd0);
    check_val("t5_srst_ovf", 32'(overflow_o), 32'd0);

    // 5b. Async reset mid-cycle
    drive_cycle(1'b1, 4'hC, 1'b0, 1'b0);
    drive_cycle(1'b1, 4'hD, 1'b0, 1'b0);
    check_val("t5_used2", 32'(used_words_o), 32'd2);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    check_val("t5_arst_used", 32'(used_words_o), 32'd0);
    check_val("t5_arst_val", 32'(next_empty_ptr_val_o), 32'd0);
    check_val("t5_arst_full", 32'(full_o), 32'd0);
    check_val("t5_arst_ovf", 32'(overflow_o), 32'd0);
    check_val("t5_arst_ptr", 32'(next_empty_ptr_o), 32'd0);
    #2 rst_n_i = 1'b1;
    drive_cycle(1'b1, 4'hE, 1'b0, 1'b0);
    check_val("t5_post_val", 32'(next_empty_ptr_val_o), 32'd1);
    check_val("t5_post_ptr", 32'(next_empty_ptr_o), 32'hE);
    check_val("t5_post_used", 32'(used_words_o), 32'd1);
    pop_expect("t5_post_drain", 4'hE);

    // 6. Wrap-around
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, AW'(i), 1'b0, 1'b0);
    check_val("t6_used12", 32'(used_words_o), 32'd12);
    for (int i = 0; i < 10; i++) pop_expect("t6_pop_a", AW'(i));
    check_val("t6_used2", 32'(used_words_o), 32'd2);
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, AW'((12 + i) % 16), 1'b0, 1'b0);
    check_val("t6_used14", 32'(used_words_o), 32'd14);
    for (int i = 0; i < 14; i++) pop_expect("t6_pop_b", AW'((10 + i) % 16));
    check_val("t6_used0", 32'(used_words_o), 32'd0);
    check_val("t6_end_val", 32'(next_empty_ptr_val_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/empty_ptr_storage.md
# empty_ptr_storage

Free-list of data-table pointers for the hash table. Sits directly downstream of the data-table init stage: it is synchronously cleared and then filled with every data-table address during OP_INIT. The insert stage pops pointers from it to allocate data-table cells, and the delete stage returns freed cells. The block is a first-word-fall-through FIFO of `A_WIDTH`-bit pointers whose capacity equals the data-table depth.

## Interface

Parameters:
- `A_WIDTH`, default `TABLE_ADDR_WIDTH`: pointer width. Capacity is `2**A_WIDTH` entries.

Ports:
- `clk_i`  in  1  sole clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `srst_i`  in  1  synchronous clear. Driven by the init stage's `empty_ptr_storage_srst_o`.
- `add_empty_ptr_i`  in  `A_WIDTH`  pointer to push.
- `add_empty_ptr_en_i`  in  1  push strobe, one pointer per cycle.
- `next_empty_ptr_o`  out  `A_WIDTH`  head-of-list pointer.
- `next_empty_ptr_val_o`  out  1  head is valid; the list is non-empty.
- `next_empty_ptr_rd_ack_i`  in  1  pop the head. Honoured only while `next_empty_ptr_val_o` is high.
- `used_words_o`  out  `A_WIDTH+1`  number of stored pointers.
- `full_o`  out  1  `used_words_o == 2**A_WIDTH`.
- `overflow_o`  out  1  sticky: a push was dropped because the list was full.

## Operation

Storage and pointers:
- Storage is a `2**A_WIDTH` × `A_WIDTH` simple dual-port RAM plus a one-entry output register (show-ahead).
- `wr_ptr` and `rd_ptr` are `A_WIDTH` bits wide and wrap modulo `2**A_WIDTH`. There is no explicit wrap logic.
- `used_words_o` is the authoritative occupancy. It counts the RAM entries plus the output register.

Push:
- A push with `add_empty_ptr_en_i=1` and `full_o=0` is accepted.
- A push while `full_o=1` is accepted only if a pop happens in the same cycle. Otherwise it is dropped, `overflow_o` is set, and no state changes.

Pop:
- `next_empty_ptr_rd_ack_i=1` while `next_empty_ptr_val_o=0` is ignored. No underflow and no counter change.

Simultaneous push and pop:
- Valid push plus valid pop in the same cycle: `used_words_o` is unchanged and both operations take effect.
- If the list held exactly one entry, the pushed pointer becomes the head on the next cycle.

Synchronous clear (`srst_i=1`):
- Pointers, `used_words_o`, `overflow_o` and `next_empty_ptr_val_o` go to 0 on the next edge.
- `srst_i` dominates any push or pop in the same cycle; those are discarded.

Ordering:
- Pointers leave in exactly the order pushed (FIFO).

Outputs:
- `next_empty_ptr_o` is the registered head value. It holds its last value while val is low; the bench must not check it then.
- `full_o` and `next_empty_ptr_val_o` are derived from registered state only. They have no combinational path from any input.

## Timing

Reset:
- On `rst_n_i` low, all outputs go to 0 immediately and asynchronously, and stay 0 until the first edge after `rst_n_i` rises.
- Reset mid-operation discards all contents.

Push-to-head latency:
- A push into an empty list in cycle N gives `next_empty_ptr_val_o=1` and `next_empty_ptr_o` equal to the pushed pointer from cycle N+1.
- The RAM read latency is hidden by bypassing the write data into the output register.

Pop throughput:
- A pop in cycle N presents the next head in cycle N+1, so the list sustains one pop per cycle back-to-back.
- The block prefetches from the RAM so that no bubble appears while `used_words_o ≥ 2`.

Counter and flag update timing:
- `used_words_o` updates one cycle after the accepted push/pop edge, i.e. it is registered.
- `full_o` follows `used_words_o` in the same cycle.
- `overflow_o` rises the cycle after the dropped push. It clears only on `srst_i` or reset.

Init traffic:
- The init stage pushes `2**A_WIDTH` consecutive pointers. The list must reach `full_o=1` exactly one cycle after the last push.

## Test plan

Use `A_WIDTH=4` (capacity 16) unless stated otherwise.

1. **Init fill and drain.** `srst_i` pulse, then push 0..15 on 16 consecutive cycles.
   - Expect `full_o=1` and `used_words_o=16` the cycle after the push of 15.
   - Then hold ack high for 16 cycles. Expect heads 0,1,…,15 on consecutive cycles, then val=0 and `used_words_o=0`.
2. **Empty-list push latency.** Push 0x7 into the empty list at cycle N.
   - Expect val=1 and ptr=0x7 at N+1.
   - Ack at N+1 → val=0 at N+2.
   - An ack with val=0 leaves `used_words_o=0`.
3. **Simultaneous push and pop.**
   - With one entry (0x3) stored, push 0x9 and ack 0x3 in the same cycle → next cycle head=0x9 and `used_words_o=1`.
   - With the list full, push 0xA plus ack in the same cycle → `used_words_o` stays 16, `overflow_o` stays 0, and 0xA is the last entry drained.
4. **Overflow.** Full list, push 0x5 with no ack.
   - Expect `overflow_o=1` next cycle, `used_words_o=16`, and a drain sequence that does not contain the extra 0x5.
   - `srst_i` clears `overflow_o`.
5. **Clear/reset mid-operation.**
   - With 9 entries stored, assert `srst_i` together with a push and an ack → next cycle `used_words_o=0`, val=0, overflow=0.
   - Refill 2 entries, then drop `rst_n_i` mid-cycle → all outputs 0 immediately. After release, the first push appears as head one cycle later.
6. **Wrap-around.** Push 12, pop 10, push 12, pop 14.
   - Expect strict FIFO order across the pointer wrap, and `used_words_o` tracking 12→2→14→0.
